// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs bytes little-endian into
// 32-bit words, writes them at sequential word addresses and holds the core meanwhile.
module imem_loader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  // Byte handshake: a byte moves exactly when in_valid && in_ready at a rising
  // edge; in_valid may rise or fall at any time and in_ready never waits on it.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(DEPTH_WORDS);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] word_idx, word_idx_n;
  logic [1:0]       byte_idx, byte_idx_n;
  logic [23:0]      shift, shift_n;
  logic             in_ready_n;
  logic             mem_we_n;
  logic [31:0]      mem_addr_n;
  logic [31:0]      mem_wdata_n;
  logic             busy_n;
  logic             done_n;
  logic             err_n;
  logic             take;
  logic             start_ok;
  logic             last_word;

  // abort wins over a byte offered in the same cycle
  assign take      = in_valid && in_ready && !abort;
  assign start_ok  = (num_words != '0) && (num_words <= DEPTH);
  assign last_word = (word_idx == count - CNT_W'(1));

  always_comb begin
    state_n     = state;
    count_n     = count;
    word_idx_n  = word_idx;
    byte_idx_n  = byte_idx;
    shift_n     = shift;
    in_ready_n  = in_ready;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    done_n      = 1'b0;
    err_n       = 1'b0;

    case (state)
      IDLE: begin
        in_ready_n = 1'b0;
        if (start) begin
          if (start_ok) begin
            state_n    = LOAD;
            count_n    = num_words;
            word_idx_n = '0;
            byte_idx_n = 2'd0;
            shift_n    = '0;
            in_ready_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      LOAD: begin
        if (abort) begin
          state_n    = IDLE;
          in_ready_n = 1'b0;
          err_n      = 1'b1;
          byte_idx_n = 2'd0;
          shift_n    = '0;
        end else if (take) begin
          byte_idx_n = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: shift_n[7:0]   = in_data;
            2'd1: shift_n[15:8]  = in_data;
            2'd2: shift_n[23:16] = in_data;
            default: begin
              // the fourth byte goes straight into the write word, so the
              // shift register is free for the next word in the write cycle
              mem_we_n    = 1'b1;
              mem_wdata_n = {in_data, shift};
              mem_addr_n  = 32'(word_idx) << 2;
              word_idx_n  = word_idx + CNT_W'(1);
              shift_n     = '0;
              if (last_word) begin
                state_n    = FLUSH;
                in_ready_n = 1'b0;
              end
            end
          endcase
        end
      end

      FLUSH: begin
        state_n    = IDLE;
        in_ready_n = 1'b0;
        done_n     = 1'b1;
      end

      default: begin
        state_n    = IDLE;
        in_ready_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= 2'd0;
      shift     <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      word_idx  <= word_idx_n;
      byte_idx  <= byte_idx_n;
      shift     <= shift_n;
      in_ready  <= in_ready_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  assign cpu_hold = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a packed-word model
// of the byte stream.
module tb_imem_loader;
  localparam int DEPTH_WORDS = 1024;
  localparam int CNT_W       = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             abort;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             busy;
  logic             cpu_hold;
  logic             done;
  logic             err;

  int n_cmp    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int we_cnt   = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  img[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every write must match the oldest expected {addr, data}
  always @(negedge clk) begin
    logic [63:0] e;
    chk("cpu_hold_eq_busy", 64'(cpu_hold), 64'(busy));
    if (mem_we === 1'b1) begin
      we_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      chk("mem_write", {mem_addr, mem_wdata}, e);
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic gen_random(input int nbytes);
    img.delete();
    for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // reference: word i = little-endian sum of bytes 4i..4i+3 at byte address 4i
  task automatic expect_words(input int nwords);
    logic [31:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = 32'(img[4*i]) + (32'(img[4*i+1]) * 256) + (32'(img[4*i+2]) * 65536)
        + (32'(img[4*i+3]) * 16777216);
      exp_q.push_back({32'(i * 4), w});
    end
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = CNT_W'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    if (in_ready !== 1'b1) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_image(input int gapmax);
    for (int i = 0; i < img.size(); i++) begin
      repeat ($urandom_range(0, gapmax)) step();
      send_byte(img[i]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int d0;
    int e0;
    int w0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    num_words = '0;
    repeat (2) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // two words back-to-back
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h82, 8'h20, 8'h00};
    expect_words(2);
    d0 = done_cnt;
    do_start(2);
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    chk("t1_cpu_hold_after_start", 64'(cpu_hold), 64'd1);
    chk("t1_in_ready_after_start", 64'(in_ready), 64'd1);
    send_image(0);
    chk("t1_mem_we_final", 64'(mem_we), 64'd1);
    chk("t1_in_ready_flush", 64'(in_ready), 64'd0);
    chk("t1_busy_flush", 64'(busy), 64'd1);
    chk("t1_done_early", 64'(done), 64'd0);
    step();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);
    step();
    chk("t1_done_one_cycle", 64'(done), 64'd0);
    chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // one word with gaps
    img = '{8'h93, 8'h85, 8'hA0, 8'h00};
    expect_words(1);
    do_start(1);
    send_image(3);
    chk("t2_mem_we", 64'(mem_we), 64'd1);
    step();
    chk("t2_done", 64'(done), 64'd1);
    step();
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // illegal counts
    e0 = err_cnt;
    do_start(0);
    chk("t3_err_zero", 64'(err), 64'd1);
    chk("t3_busy_zero", 64'(busy), 64'd0);
    chk("t3_in_ready_zero", 64'(in_ready), 64'd0);
    step();
    chk("t3_err_pulse", 64'(err), 64'd0);
    do_start(1025);
    chk("t3_err_big", 64'(err), 64'd1);
    chk("t3_busy_big", 64'(busy), 64'd0);
    chk("t3_cpu_hold_big", 64'(cpu_hold), 64'd0);
    chk("t3_in_ready_big", 64'(in_ready), 64'd0);
    step();
    chk("t3_err_count", 64'(err_cnt - e0), 64'd2);

    // abort after six bytes; the abort-cycle byte is offered and must be dropped
    gen_random(6);
    expect_words(1);
    d0 = done_cnt;
    do_start(3);
    send_image(0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    step();
    chk("t4_err_pulse", 64'(err), 64'd0);
    img = '{8'h13, 8'h00, 8'h00, 8'h00};
    expect_words(1);
    do_start(1);
    send_image(0);
    step(); step();
    chk("t4_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // abort in IDLE and in FLUSH is ignored
    e0 = err_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_idle_abort_err", 64'(err), 64'd0);
    gen_random(4);
    expect_words(1);
    do_start(1);
    send_image(0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_flush_abort_done", 64'(done), 64'd1);
    chk("t5_flush_abort_err", 64'(err), 64'd0);
    step();
    chk("t5_err_count", 64'(err_cnt - e0), 64'd0);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-word
    e0 = err_cnt; d0 = done_cnt;
    gen_random(2);
    do_start(2);
    send_image(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("t6_midload");
    gen_random(4);
    expect_words(1);
    do_start(1);
    send_image(1);
    step(); step();
    chk("t6_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t6_err_count", 64'(err_cnt - e0), 64'd0);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // full memory with random bytes and a stray start mid-load
    gen_random(4 * DEPTH_WORDS);
    expect_words(DEPTH_WORDS);
    d0 = done_cnt; w0 = we_cnt;
    do_start(DEPTH_WORDS);
    for (int i = 0; i < img.size(); i++) begin
      if ($urandom_range(0, 7) == 0) step();
      if (i == 2001) begin
        start = 1'b1;
        num_words = CNT_W'(5);
      end
      send_byte(img[i]);
      start = 1'b0;
    end
    chk("t7_in_ready_flush", 64'(in_ready), 64'd0);
    step();
    chk("t7_done", 64'(done), 64'd1);
    step();
    chk("t7_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t7_write_count", 64'(we_cnt - w0), 64'(DEPTH_WORDS));
    chk("t7_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion of the instruction memory: takes a byte stream over a valid/ready interface and packs bytes little-endian into 32-bit words.
- Issues one write per word, at sequential word-aligned byte addresses from 0, on the memory's write port.
- Holds the core (`cpu_hold`) for the whole load and pulses `done` when the program image is complete.
- Sits between the host link (UART/JTAG byte bridge) and the instruction memory write port.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words.
- CNT_W, 11, width of the word-count input; must hold DEPTH_WORDS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- num_words  input  CNT_W  words to load; sampled with start; legal range 1..DEPTH_WORDS.
- abort  input  1  cancels an in-progress load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte when in_valid && in_ready.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  32  byte address of the write; always word aligned (bits[1:0]=0).
- mem_wdata  output  32  assembled word.
- busy  output  1  high in LOAD and FLUSH.
- cpu_hold  output  1  keeps the core in reset/stall; equals busy.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on illegal start or abort.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, cpu_hold=0, done=0, err=0; state=IDLE; byte_idx=0; word_idx=0; shift register cleared.
- Reset mid-load discards partial bytes and sets no done/err.
- States: IDLE, LOAD, FLUSH.
- IDLE, start with 1<=num_words<=DEPTH_WORDS:
  - Latch count; word_idx=0; byte_idx=0.
  - Next cycle: state LOAD, busy=cpu_hold=1, in_ready=1.
- IDLE, start with num_words=0 or >DEPTH_WORDS: err=1 next cycle; stay IDLE.
- start outside IDLE is ignored.
- LOAD, byte handshake:
  - Byte goes to lane byte_idx (byte 0 → bits[7:0], byte 3 → bits[31:24]).
  - byte_idx increments mod 4.
  - Cycles with in_valid=0 change nothing.
- LOAD, 4th byte accepted in cycle N; in cycle N+1:
  - mem_we=1, mem_wdata=assembled word, mem_addr=word_idx*4.
  - word_idx increments after the write.
- mem_we lasts exactly one cycle per word; it is never asserted in other cycles.
- in_ready stays 1 during the write cycle of a non-final word, so back-to-back bytes are accepted.
  - A byte taken in cycle N+1 starts the next word; the shift register is separate from mem_wdata.
- Final word, 4th byte accepted in cycle N:
  - State goes to FLUSH; in_ready=0 from cycle N+1.
  - mem_we for the final word in cycle N+1.
  - Cycle N+2: state IDLE, done=1 (one cycle), busy=cpu_hold=0.
- abort in LOAD, same-cycle handshake:
  - The abort takes priority; the byte is dropped.
  - Next cycle: state IDLE, in_ready=0, busy=cpu_hold=0, err=1.
  - Partial word is discarded and no mem_we is issued for it; words already written stay in memory.
- abort in FLUSH is ignored: the final write and done still happen.
- abort in IDLE is ignored.
- Address wrap is impossible: word_idx never exceeds count-1 <= DEPTH_WORDS-1.
  - Max mem_addr = 4*(DEPTH_WORDS-1) = 0xFFC at default.
- The loader never reads the memory; readback is the fetch path's job.

Test Plan:
- start, num_words=2; bytes 13 00 00 00 B3 82 20 00 back-to-back → mem_we at addr 0x0 data 0x00000013, then addr 0x4 data 0x002082B3; done pulses 2 cycles after the last handshake; cpu_hold high from the cycle after start through the cycle before done.
- num_words=1 with in_valid gaps of 0–3 cycles between bytes 93 85 A0 00 → single write addr 0x0 data 0x00A08593; mem_we exactly one cycle; no writes during gaps.
- start with num_words=0, then with num_words=1025 → err pulse each time; busy, cpu_hold and in_ready stay 0; no mem_we.
- num_words=3; abort after 6 bytes → one write (addr 0x0) only; err=1, done=0; the next start (num_words=1, bytes 13 00 00 00) writes addr 0x0 data 0x00000013 with no residue from the partial word.
- rst asserted mid-word during a load → all outputs at reset values next cycle; a fresh load starts from byte lane 0 and address 0.
- num_words=1024 with random bytes → 1024 writes, addresses 0x000..0xFFC incrementing by 4; data matches the packed stream; exactly one done; start pulsed during the load is ignored.
